// File: rtl/uart_pkg.sv
// uart_pkg: UART-lite register map, status bit indices and loader state encoding.
// CHECK exists only when UART_LOADER_CHECKSUM_EN is defined.
package uart_pkg;
  localparam logic [3:0] RX_FIFO  = 4'h0;
  localparam logic [3:0] TX_FIFO  = 4'h4;
  localparam logic [3:0] STAT_REG = 4'h8;
  localparam logic [3:0] CTRL_REG = 4'hC;
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 3;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    STAT_AR  = 4'd1,
    STAT_R   = 4'd2,
    DATA_AR  = 4'd3,
    DATA_R   = 4'd4,
    ASSEMBLE = 4'd5,
    WRITE    = 4'd6,
`ifdef UART_LOADER_CHECKSUM_EN
    CHECK    = 4'd7,
`endif
    FIN      = 4'd8
  } state_t;
endpackage

// File: rtl/uart_axi_reader.sv
// uart_axi_reader: AXI4-lite read handshake (AR then R phase) toward the UART-lite.
// An error response is reported as o_r_bad so the caller re-issues the same read.
module uart_axi_reader
  import uart_pkg::*;
(
  input  logic        i_ar,
  input  logic        i_r,
  input  logic [3:0]  i_addr,
  output logic [3:0]  uart_axi_araddr,
  output logic        uart_axi_arvalid,
  input  logic        uart_axi_arready,
  input  logic [31:0] uart_axi_rdata,
  input  logic [1:0]  uart_axi_rresp,
  input  logic        uart_axi_rvalid,
  output logic        uart_axi_rready,
  output logic        o_ar_done,
  output logic        o_r_ok,
  output logic        o_r_bad,
  output logic        o_rx_valid,
  output logic [7:0]  o_byte
);
  logic w_r_hs;
  logic w_unused;
  assign uart_axi_araddr  = i_addr;
  assign uart_axi_arvalid = i_ar;
  assign uart_axi_rready  = i_r;
  assign o_ar_done  = i_ar & uart_axi_arready;
  assign w_r_hs     = i_r & uart_axi_rvalid;
  assign o_r_ok     = w_r_hs & (uart_axi_rresp == RESP_OKAY);
  assign o_r_bad    = w_r_hs & (uart_axi_rresp != RESP_OKAY);
  assign o_rx_valid = uart_axi_rdata[STAT_RX_VALID];
  assign o_byte     = uart_axi_rdata[7:0];
  assign w_unused   = &{1'b0, uart_axi_rdata[31:8]};
endmodule

// File: rtl/uart_loader.sv
// uart_loader: polls a UART-lite over AXI4-lite, reads a big-endian word count then
// that many words into program memory. UART_LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module uart_loader
  import uart_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic [3:0]        uart_axi_araddr,
  output logic              uart_axi_arvalid,
  input  logic              uart_axi_arready,
  input  logic [31:0]       uart_axi_rdata,
  input  logic [1:0]        uart_axi_rresp,
  input  logic              uart_axi_rvalid,
  output logic              uart_axi_rready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
`ifdef UART_LOADER_CHECKSUM_EN
  localparam state_t S_END = CHECK;
`else
  localparam state_t S_END = FIN;
`endif
  state_t      r_state, w_next;
  logic        w_ar_done, w_r_ok, w_r_bad, w_rx_valid, w_chk, w_last;
  logic [7:0]  w_byte;
  logic [1:0]  r_bcnt;
  logic        r_hdr, r_busy, r_done;
  logic [31:0] r_n, r_wcnt, r_asm;
  uart_axi_reader u_rd (
    .i_ar             (r_state == STAT_AR || r_state == DATA_AR),
    .i_r              (r_state == STAT_R || r_state == DATA_R),
    .i_addr           (r_state == DATA_AR ? RX_FIFO : STAT_REG),
    .uart_axi_araddr  (uart_axi_araddr),
    .uart_axi_arvalid (uart_axi_arvalid),
    .uart_axi_arready (uart_axi_arready),
    .uart_axi_rdata   (uart_axi_rdata),
    .uart_axi_rresp   (uart_axi_rresp),
    .uart_axi_rvalid  (uart_axi_rvalid),
    .uart_axi_rready  (uart_axi_rready),
    .o_ar_done        (w_ar_done),
    .o_r_ok           (w_r_ok),
    .o_r_bad          (w_r_bad),
    .o_rx_valid       (w_rx_valid),
    .o_byte           (w_byte)
  );
  assign mem_we    = r_state == WRITE;
  assign mem_addr  = r_wcnt[ADDR_W-1:0];
  assign mem_wdata = r_asm;
  assign busy      = r_busy;
  assign done      = r_done;
  assign w_last    = (r_wcnt + 32'd1) == r_n;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = start ? STAT_AR : IDLE;
      STAT_AR:  w_next = w_ar_done ? STAT_R : STAT_AR;
      STAT_R:   w_next = w_r_ok ? (w_rx_valid ? DATA_AR : STAT_AR) : (w_r_bad ? STAT_AR : STAT_R);
      DATA_AR:  w_next = w_ar_done ? DATA_R : DATA_AR;
      DATA_R:   w_next = w_r_ok ? (w_chk ? FIN : ASSEMBLE) : (w_r_bad ? DATA_AR : DATA_R);
      ASSEMBLE: w_next = (r_bcnt != 2'd0) ? STAT_AR : (r_hdr ? WRITE : (r_asm == 32'd0 ? S_END : STAT_AR));
      WRITE:    w_next = w_last ? S_END : STAT_AR;
`ifdef UART_LOADER_CHECKSUM_EN
      CHECK:    w_next = STAT_AR;
`endif
      FIN:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_bcnt  <= 2'd0;
      r_hdr   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_n     <= 32'd0;
      r_wcnt  <= 32'd0;
      r_asm   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_bcnt <= 2'd0;
        r_hdr  <= 1'b0;
        r_n    <= 32'd0;
        r_wcnt <= 32'd0;
      end
      if (r_state == DATA_R && w_r_ok) begin
        r_asm  <= {r_asm[23:0], w_byte};
        r_bcnt <= r_bcnt + 2'd1;
      end
      // the first completed word is the header count, never written to memory
      if (r_state == ASSEMBLE && r_bcnt == 2'd0 && !r_hdr) begin
        r_hdr <= 1'b1;
        r_n   <= r_asm;
      end
      if (r_state == WRITE) r_wcnt <= r_wcnt + 32'd1;
      if (r_state == FIN) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end
`ifdef UART_LOADER_CHECKSUM_EN
  logic       r_chk, r_err;
  logic [7:0] r_xor;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_chk <= 1'b0;
      r_err <= 1'b0;
      r_xor <= 8'd0;
    end else begin
      if (r_state == IDLE && start) begin
        r_chk <= 1'b0;
        r_err <= 1'b0;
        r_xor <= 8'd0;
      end
      if (r_state == CHECK) r_chk <= 1'b1;
      if (r_state == DATA_R && w_r_ok && r_chk) r_err <= w_byte != r_xor;
      if (r_state == DATA_R && w_r_ok && !r_chk && r_hdr) r_xor <= r_xor ^ w_byte;
    end
  end
  assign w_chk = r_chk;
  assign err   = r_err;
`else
  assign w_chk = 1'b0;
  assign err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed checks of uart_loader against a UART-lite AXI read responder model.
module tb_uart_loader;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  logic        clk = 1'b0, rstn = 1'b1, start = 1'b0;
  logic [3:0]  araddr;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0, rready;
  logic        mem_we, busy, done, err;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  uart_loader #(.ADDR_W(14)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid), .uart_axi_arready(arready),
    .uart_axi_rdata(rdata), .uart_axi_rresp(rresp), .uart_axi_rvalid(rvalid), .uart_axi_rready(rready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  logic [7:0]  q[$];
  logic [13:0] wa[$];
  logic [31:0] wd[$];
  logic        hs_ar = 1'b0, hs_r = 1'b0, in_wait = 1'b0, rx_ok = 1'b0;
  logic [3:0]  ar_addr = 4'd0, held = 4'd0;
  int ar_dly = 0, poll_n = 0, err_once = 0, polls_left = 0, wait_cnt = 0;
  int unstable = 0, data_bad = 0, stat_cnt = 0, ar_cnt = 0, n_bytes = 0;
  always @(negedge clk) if (rstn && mem_we) begin
    wa.push_back(mem_addr);
    wd.push_back(mem_wdata);
  end
  // responder: acts at negedges on handshakes that happened at the preceding posedge
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      arready = 1'b0; rvalid = 1'b0; hs_ar = 1'b0; hs_r = 1'b0; in_wait = 1'b0;
    end else begin
      if (hs_r) rvalid = 1'b0;
      if (hs_ar) begin
        arready = 1'b0;
        rvalid = 1'b1;
        ar_cnt++;
        if (err_once > 0) begin
          rresp = 2'b10; rdata = 32'hFFFF_FFFF; err_once--;
        end else if (ar_addr == 4'h8) begin
          rresp = 2'b00;
          stat_cnt++;
          if (polls_left == 0 && q.size() > 0) begin
            rdata = 32'h0000_0001; rx_ok = 1'b1;
          end else begin
            rdata = 32'hFFFF_FFFE; rx_ok = 1'b0;
            if (polls_left > 0) polls_left--;
          end
        end else begin
          rresp = 2'b00;
          if (!rx_ok || q.size() == 0) data_bad++;
          rdata = (q.size() > 0) ? {24'h5A5A5A, q.pop_front()} : 32'd0;
          polls_left = poll_n;
          rx_ok = 1'b0;
        end
      end
      if (in_wait && !arvalid && !hs_ar) unstable++;
      if (arvalid && !arready) begin
        if (!in_wait) begin
          in_wait = 1'b1; held = araddr; wait_cnt = 0;
        end else if (araddr != held) unstable++;
        if (wait_cnt >= ar_dly) arready = 1'b1;
        else wait_cnt++;
      end
      hs_ar = arvalid && arready;
      if (hs_ar) begin
        ar_addr = araddr; in_wait = 1'b0;
      end
      hs_r = rvalid && rready;
    end
  end
  task automatic push_word(input logic [31:0] w);
    q.push_back(w[31:24]); q.push_back(w[23:16]); q.push_back(w[15:8]); q.push_back(w[7:0]);
  endtask
  task automatic add_sum(input logic [7:0] b);
    if (CSUM) q.push_back(b);
  endtask
  task automatic load(input int polls, input int dly, input int errs);
    poll_n = polls; polls_left = polls; ar_dly = dly; err_once = errs;
    unstable = 0; data_bad = 0; stat_cnt = 0; ar_cnt = 0; rx_ok = 1'b0;
    n_bytes = q.size();
    wa.delete(); wd.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input logic exp_err);
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk); n++;
    end
    check({tag, "_timeout"}, 32'(n >= 5000), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    check({tag, "_rready"}, 32'(rready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_araddr"}, 32'(araddr), 32'h8);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask
  task automatic check_image2(input string tag);
    check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    check({tag, "_a0"}, 32'(wa[0]), 32'd0);
    check({tag, "_d0"}, wd[0], 32'hDEADBEEF);
    check({tag, "_a1"}, 32'(wa[1]), 32'd1);
    check({tag, "_d1"}, wd[1], 32'h01234567);
  endtask
  initial begin
    int n;
    #2 rstn = 1'b0;
    #1 check_reset("rst");
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    // basic two-word load
    q.delete(); push_word(32'd2); push_word(32'hDEADBEEF); push_word(32'h01234567); add_sum(8'h22);
    load(0, 0, 0);
    wait_done("t1", 1'b0);
    check_image2("t1");
    // five not-ready polls before every byte
    q.delete(); push_word(32'd2); push_word(32'hDEADBEEF); push_word(32'h01234567); add_sum(8'h22);
    load(5, 0, 0);
    wait_done("t2", 1'b0);
    check_image2("t2");
    check("t2_data_while_empty", 32'(data_bad), 32'd0);
    check("t2_status_reads", 32'(stat_cnt), 32'(n_bytes * 6));
    // slow arready and one SLVERR
    q.delete(); push_word(32'd1); push_word(32'hDEADBEEF); add_sum(8'h22);
    load(0, 3, 1);
    wait_done("t3", 1'b0);
    check("t3_unstable", 32'(unstable), 32'd0);
    check("t3_reads", 32'(ar_cnt), 32'(2 * n_bytes + 1));
    check("t3_nwr", 32'(wa.size()), 32'd1);
    check("t3_a0", 32'(wa[0]), 32'd0);
    check("t3_d0", wd[0], 32'hDEADBEEF);
    // empty image
    q.delete(); push_word(32'd0); add_sum(8'h00);
    load(0, 0, 0);
    wait_done("t4", 1'b0);
    check("t4_nwr", 32'(wa.size()), 32'd0);
    check("t4_reads", 32'(ar_cnt), 32'(2 * n_bytes));
    // reset in the middle of the second word, then reload
    q.delete(); push_word(32'd2); push_word(32'hDEADBEEF); push_word(32'h01234567); add_sum(8'h22);
    load(0, 0, 0);
    n = 0;
    while ((wa.size() < 1 || q.size() > 2) && n < 5000) begin
      @(negedge clk); n++;
    end
    check("t5_reach_word2", 32'(n < 5000), 32'd1);
    #2 rstn = 1'b0;
    #1 check_reset("t5");
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    q.delete(); push_word(32'd2); push_word(32'hDEADBEEF); push_word(32'h01234567); add_sum(8'h22);
    load(0, 0, 0);
    wait_done("t5r", 1'b0);
    check_image2("t5r");
`ifdef UART_LOADER_CHECKSUM_EN
    q.delete(); push_word(32'd1); push_word(32'hDEADBEEF); q.push_back(8'h22);
    load(0, 0, 0);
    wait_done("t6_good", 1'b0);
    q.delete(); push_word(32'd1); push_word(32'hDEADBEEF); q.push_back(8'h23);
    load(0, 0, 0);
    wait_done("t6_bad", 1'b1);
    check("t6_bad_word", wd[0], 32'hDEADBEEF);
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: word-address width of the memory write port.
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that begins a load.
REQ-005 SHALL have ports uart_axi_araddr (output, 4), uart_axi_arvalid (output, 1) and uart_axi_arready (input, 1): AXI4-lite read-address channel to the UART-lite.
REQ-006 SHALL have ports uart_axi_rdata (input, 32), uart_axi_rresp (input, 2), uart_axi_rvalid (input, 1) and uart_axi_rready (output, 1): AXI4-lite read-data channel.
REQ-007 SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, 32): word write port to program memory.
REQ-008 SHALL have ports busy (output, 1) and done (output, 1): load in progress, and load finished (sticky).
REQ-009 SHALL have port err (output, 1): checksum mismatch, sticky.

Function
REQ-010 SHALL use states IDLE, STAT_AR, STAT_R, DATA_AR, DATA_R, ASSEMBLE, WRITE, CHECK and FIN.
REQ-011 SHALL move IDLE->STAT_AR on start, clear done/err, zero byte and word counters, and set busy.
REQ-012 SHALL drive araddr=0x8 (status) in STAT_AR and araddr=0x0 (RX FIFO) in DATA_AR, holding arvalid high with araddr stable until the cycle arvalid&arready is high, then go to the matching R state.
REQ-013 SHALL assert rready only in STAT_R/DATA_R and capture rdata in the cycle rvalid&rready is high.
REQ-014 SHALL, on a status capture, go to DATA_AR if rdata[0] (RX valid)=1, else back to STAT_AR.
REQ-015 SHALL treat any rresp!=OKAY as not-accepted and re-issue the same read (status or data).
REQ-016 SHALL shift each received byte rdata[7:0] into a 32-bit assembly register big-endian (first byte lands in [31:24]), then go to ASSEMBLE.
REQ-017 SHALL use the first 4 bytes as the 32-bit header word count N, not written to memory.
REQ-018 SHALL, after every subsequent 4th byte, enter WRITE for exactly one cycle with mem_we=1, mem_wdata=assembled word and mem_addr=word index (0,1,2,...), then increment the index.
REQ-019 SHALL let mem_addr wrap modulo 2^ADDR_W when N exceeds 2^ADDR_W.
REQ-020 SHALL, when the header gives N=0, proceed directly to CHECK/FIN with no memory writes.
REQ-021 SHALL, after N words, go to CHECK (only with the macro) or FIN; FIN clears busy, sets done, and returns to IDLE.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL keep mem_we low outside WRITE, arvalid low outside *_AR states, and rready low outside *_R states.

Reset
REQ-024 SHALL, on rstn low at any time including mid-load or mid-handshake, immediately enter IDLE with arvalid, rready, mem_we, busy, done and err at 0, araddr=0x8, mem_addr=0, mem_wdata=0, and all counters cleared.

Configuration
REQ-025 SHALL, with macro UART_LOADER_CHECKSUM_EN defined, XOR all payload bytes (header excluded), read one extra trailing byte in CHECK via the normal status-poll/data-read path, and set err=1 if it differs from the XOR.
REQ-026 SHALL, without UART_LOADER_CHECKSUM_EN, omit the CHECK state and tie err to 0.

Structure
REQ-027 SHALL place the UART-lite register offsets (RX_FIFO=0x0, TX_FIFO=0x4, STAT_REG=0x8, CTRL_REG=0xC), the status bit indices (RX valid=0, TX full=3) and the state encoding in the shared package uart_pkg.
REQ-028 SHALL implement the AXI read handshake (AR+R phases, retry on rresp) as one sub-module uart_axi_reader, instantiated once.

Verification
REQ-029 SHALL check: model delivers bytes 00 00 00 02, DE AD BE EF, 01 23 45 67 -> writes addr0=DEADBEEF, addr1=01234567, then done=1, busy=0.
REQ-030 SHALL check: status returns rdata[0]=0 for 5 polls before each byte -> same memory image, with no data read issued while RX valid=0.
REQ-031 SHALL check: arready delayed 3 cycles and rresp=SLVERR once -> araddr/arvalid stable while waiting, read retried, correct word written.
REQ-032 SHALL check: header 00 00 00 00 -> no mem_we pulse, done=1.
REQ-033 SHALL check: rstn pulsed low mid-word-2, then start re-issued -> all outputs at reset values immediately, and the reload starts again at addr0.
REQ-034 SHALL check (with UART_LOADER_CHECKSUM_EN): payload DEADBEEF plus trailing byte 0x22 -> err=0; with trailing byte 0x23 -> err=1.
